// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state type and sizing helpers for the UART TX arbiter
package uart_tx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, SEND, GAP} state_t;
    localparam int DEFAULT_HOLD_TIMEOUT = 1024;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_HOLD_TIMEOUT);
    function automatic int cnt_width(int timeout);
        return $clog2(timeout);
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the avr_interface TX channel
//   req_valid/req_data/req_last : per-requester byte offer (data of requester i at [8i+7:8i])
//   req_ready                   : per-requester accept strobe
//   grant                       : one-hot current owner
//   tx_data/new_tx_data/tx_busy : avr_interface serial TX channel
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           tx_data;
    logic                 new_tx_data;
    logic                 tx_busy;
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_data, new_tx_data
    );
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_data, new_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker, first set bit of req at or above ptr (wrapping)
//   req    : request vector
//   ptr    : highest-priority index
//   onehot : winning requester, one-hot (0 if none)
//   idx    : index of the winner
module uart_tx_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] j;
    // Scan from the farthest offset down so the closest match to ptr is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        j      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of the avr_interface TX byte channel
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : requester streams in, avr_interface tx_data/new_tx_data/tx_busy out (slave side)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int HOLD_TIMEOUT = DEFAULT_HOLD_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(HOLD_TIMEOUT);
    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      g;
    logic [CW-1:0]      cnt;
    logic               last_q;
    logic [7:0]         tx_q;
    logic               new_q;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               accept;
    logic [IW-1:0]      g_next;
    uart_tx_arbiter_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );
    assign accept          = state == HOLD && bus.req_valid[g] && !bus.tx_busy;
    assign g_next          = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    assign bus.req_ready   = accept ? grant_q : '0;
    assign bus.grant       = grant_q;
    assign bus.tx_data     = tx_q;
    assign bus.new_tx_data = new_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
            g       <= '0;
            cnt     <= '0;
            last_q  <= 1'b0;
            tx_q    <= '0;
            new_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req_valid) begin
                    grant_q <= pick_oh;
                    g       <= pick_idx;
                    cnt     <= '0;
                    state   <= HOLD;
                end
                HOLD: if (accept) begin
                    tx_q   <= bus.req_data[{g, 3'b000} +: 8];
                    last_q <= bus.req_last[g];
                    cnt    <= '0;
                    new_q  <= 1'b1;
                    state  <= SEND;
                end else if (!bus.req_valid[g]) begin
                    // Only an absent owner counts toward revocation; backpressure never does.
                    if (cnt == CW'(HOLD_TIMEOUT - 1)) begin
                        grant_q <= '0;
                        ptr     <= g_next;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    new_q <= 1'b0;
                    state <= GAP;
                end
                GAP: if (last_q) begin
                    grant_q <= '0;
                    ptr     <= g_next;
                    state   <= IDLE;
                end else begin
                    cnt   <= '0;
                    state <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and sequence checks of uart_tx_arbiter (NUM_REQ=2, HOLD_TIMEOUT=16)
module tb_uart_tx_arbiter;
    typedef struct {
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        busy;
        logic [1:0]  ready;
        logic [1:0]  grant;
        logic        nw;
        logic [7:0]  tx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy = 1'b0;
    int checks = 0;
    int errors = 0;
    int bad_ready = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];
    vec_t tv[12];

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus();
    uart_tx_arbiter #(.NUM_REQ(2), .HOLD_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic zero_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_busy   = 1'b0;
    endtask

    // One cycle of the requester model: offer queue heads, log strobes, pop on accept.
    task automatic step();
        @(negedge clk);
        bus.req_valid = {q1.size() > 0, q0.size() > 0};
        bus.req_data  = {q1.size() > 0 ? q1[0][7:0] : 8'h00, q0.size() > 0 ? q0[0][7:0] : 8'h00};
        bus.req_last  = {q1.size() > 0 ? q1[0][8] : 1'b0, q0.size() > 0 ? q0[0][8] : 1'b0};
        bus.tx_busy   = busy;
        #1;
        if ((bus.req_ready & ~bus.grant) != 2'b00) bad_ready++;
        if (bus.new_tx_data) log_q.push_back({bus.grant, bus.tx_data});
        if (bus.req_ready[0]) void'(q0.pop_front());
        if (bus.req_ready[1]) void'(q1.pop_front());
    endtask

    task automatic drain(string n);
        int k = 0;
        while ((q0.size() + q1.size()) != 0 && k < 80) begin
            step();
            k++;
        end
        chk({n, "_drain"}, q0.size() + q1.size(), 0);
        repeat (4) step();
    endtask

    task automatic ex(logic [1:0] gnt, logic [7:0] d);
        exp_q.push_back({gnt, d});
    endtask

    task automatic check_log(string n);
        chk({n, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_byte%0d", n, i), int'(log_q[i]), int'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        q0.delete();
        q1.delete();
        log_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        tv[0]  = '{2'b01, 16'h0048, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00};
        tv[1]  = '{2'b01, 16'h0048, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00};
        tv[2]  = '{2'b01, 16'h0069, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 8'h48};
        tv[3]  = '{2'b01, 16'h0069, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 8'h48};
        tv[4]  = '{2'b01, 16'h0069, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h48};
        tv[5]  = '{2'b01, 16'h000A, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 8'h69};
        tv[6]  = '{2'b01, 16'h000A, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 8'h69};
        tv[7]  = '{2'b01, 16'h000A, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 8'h69};
        tv[8]  = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1, 8'h0A};
        tv[9]  = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 8'h0A};
        tv[10] = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h0A};
        tv[11] = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h0A};

        // Reset values, with requests present while reset is held.
        zero_inputs();
        bus.req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_new", bus.new_tx_data, 0);
        chk("rst_tx", bus.tx_data, 0);
        zero_inputs();
        rst = 1'b0;

        // Single requester, 3-byte packet, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.req_valid = tv[i].valid;
            bus.req_data  = tv[i].data;
            bus.req_last  = tv[i].last;
            bus.tx_busy   = tv[i].busy;
            #1;
            chk($sformatf("tv%0d_ready", i), bus.req_ready, tv[i].ready);
            chk($sformatf("tv%0d_grant", i), bus.grant, tv[i].grant);
            chk($sformatf("tv%0d_new", i), bus.new_tx_data, tv[i].nw);
            chk($sformatf("tv%0d_tx", i), bus.tx_data, tv[i].tx);
        end

        // Simultaneous requests at reset release: pointer 0 favours req0.
        do_reset();
        q0 = '{9'h011, 9'h112};
        q1 = '{9'h021, 9'h122};
        drain("simul");
        ex(2'b01, 8'h11); ex(2'b01, 8'h12); ex(2'b10, 8'h21); ex(2'b10, 8'h22);
        check_log("simul");

        // After a lone req0 packet the pointer favours req1.
        q0 = '{9'h131};
        drain("lone0");
        ex(2'b01, 8'h31);
        check_log("lone0");
        q0 = '{9'h041, 9'h142};
        q1 = '{9'h051, 9'h152};
        drain("repeat");
        ex(2'b10, 8'h51); ex(2'b10, 8'h52); ex(2'b01, 8'h41); ex(2'b01, 8'h42);
        check_log("repeat");

        // Packet lock: req1 arrives after req0's first byte and must wait.
        q0 = '{9'h0A1, 9'h0A2, 9'h1A3};
        k = 0;
        while (q0.size() == 3 && k < 20) begin
            step();
            k++;
        end
        chk("lock_first_accept", q0.size(), 2);
        q1 = '{9'h0B1, 9'h1B2};
        drain("lock");
        ex(2'b01, 8'hA1); ex(2'b01, 8'hA2); ex(2'b01, 8'hA3); ex(2'b10, 8'hB1); ex(2'b10, 8'hB2);
        check_log("lock");

        // Backpressure for 50 cycles must neither send nor time out.
        busy = 1'b1;
        q0 = '{9'h1C5};
        repeat (50) step();
        chk("bp_no_strobe", log_q.size(), 0);
        chk("bp_grant_kept", bus.grant, 2'b01);
        busy = 1'b0;
        k = 0;
        while (log_q.size() == 0 && k < 10) begin
            step();
            k++;
        end
        chk("bp_latency", k, 2);
        drain("bp");
        ex(2'b01, 8'hC5);
        check_log("bp");

        // Timeout: req0 stalls mid-packet, grant revoked after 16 HOLD cycles, req1 then served.
        q0 = '{9'h0D1};
        k = 0;
        while (q0.size() != 0 && k < 20) begin
            step();
            k++;
        end
        chk("to_accept", q0.size(), 0);
        q1 = '{9'h1E1};
        step();
        chk("to_strobe", bus.new_tx_data, 1);
        k = 0;
        while (bus.grant == 2'b01 && k < 40) begin
            step();
            k++;
        end
        chk("to_cycles", k, 18);
        chk("to_grant_clear", bus.grant, 2'b00);
        step();
        chk("to_grant_req1", bus.grant, 2'b10);
        drain("to");
        ex(2'b01, 8'hD1); ex(2'b10, 8'hE1);
        check_log("to");

        // Reset in SEND: outputs clear at once, pointer returns to 0.
        q0 = '{9'h155};
        drain("pre_rst");
        ex(2'b01, 8'h55);
        check_log("pre_rst");
        q1 = '{9'h0F1, 9'h1F2};
        k = 0;
        while (!bus.new_tx_data && k < 10) begin
            step();
            k++;
        end
        chk("mid_send_seen", bus.new_tx_data, 1);
        chk("mid_send_grant", bus.grant, 2'b10);
        rst = 1'b1;
        #1;
        chk("arst_new", bus.new_tx_data, 0);
        chk("arst_grant", bus.grant, 0);
        chk("arst_tx", bus.tx_data, 0);
        chk("arst_ready", bus.req_ready, 0);
        do_reset();
        q0 = '{9'h1A7};
        q1 = '{9'h1B7};
        drain("post_rst");
        ex(2'b01, 8'hA7); ex(2'b10, 8'hB7);
        check_log("post_rst");

        chk("nonowner_ready", bad_ready, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single avr_interface serial TX byte channel between NUM_REQ byte-stream requesters (e.g. hello printer, PDM sample streamer).
- Arbitration is round-robin with packet lock: a grant is held from a requester's first byte until its byte flagged last, so packets never interleave on the AVR serial link.
- Sits between the requesters and avr_interface tx_data/new_tx_data/tx_busy.
- Releases a stalled grant after a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- HOLD_TIMEOUT, 1024, idle cycles in HOLD (granted requester not valid) before the grant is revoked (>=2).

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  requester i presents a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  presented byte ends requester i's packet
- req_ready  out  NUM_REQ  combinational; byte of requester i accepted this cycle
- grant  out  NUM_REQ  registered one-hot current owner, 0 when idle
- tx_data  out  8  byte to avr_interface
- new_tx_data  out  1  one-cycle strobe to avr_interface
- tx_busy  in  1  avr_interface busy/blocked

Behaviour:
- Clock/reset: one clock domain. Asynchronous reset, active-high.
- Reset values: state=IDLE, grant=0, tx_data=0, new_tx_data=0, rr pointer=0, timeout counter=0, latched last=0. req_ready is 0 while rst is high.
- States: IDLE, HOLD, SEND, GAP.
- IDLE:
  - If req_valid is nonzero, choose the first set bit searching upward from pointer p, wrapping modulo NUM_REQ.
  - Set grant to that one-hot, clear the counter, go to HOLD.
  - No byte is accepted in IDLE.
- HOLD, owner g:
  - Accept when req_valid[g] && !tx_busy. In that cycle req_ready[g]=1; latch req_data[g] into tx_data and req_last[g] into last; clear the counter; go to SEND.
  - Else, if !req_valid[g], increment the counter.
  - When the counter reaches HOLD_TIMEOUT-1 with no accept: grant<=0, p<=(g+1) mod NUM_REQ, go to IDLE.
  - tx_busy high with valid high does not count toward the timeout.
- SEND: new_tx_data=1 for exactly this cycle; tx_data held stable. Go to GAP.
- GAP:
  - One dead cycle so tx_busy from avr_interface reflects the new byte.
  - If last: grant<=0, p<=(g+1) mod NUM_REQ, go to IDLE.
  - Else go to HOLD with the counter cleared.
- req_ready bits for non-owners are always 0. Requests from non-owners are ignored until IDLE.
- tx_data holds its value outside SEND.
- Latency: first accept occurs 1 cycle after req_valid rises (IDLE->HOLD). The strobe follows 1 cycle after accept. Minimum 3 cycles per byte.
- Simultaneous requests in IDLE: the pointer decides. With p=0, requester 0 wins; after its packet p=1.
- A 1-byte packet has req_last set on its first byte.
- A change to req_data[g] while unaccepted is permitted. The byte latched is the value in the accept cycle.
- Asynchronous reset mid-packet: the partial packet is dropped, any pending strobe is cancelled, and the arbiter restarts from p=0.

Decomposition:
- Shared package: state enum (IDLE, HOLD, SEND, GAP); constants for DEFAULT_HOLD_TIMEOUT and the counter width (clog2(HOLD_TIMEOUT)).
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the req vector and pointer p; outputs are a one-hot result and its index. Reusable by other arbiters.

Test Plan:
- Single requester, 3 bytes:
  - Stimulus: req0 sends 0x48, 0x69, 0x0A (last), tx_busy=0.
  - Expected: exactly 3 new_tx_data pulses with those bytes in order, spaced 3 cycles apart; grant=01 throughout, then 00.
- Simultaneous requests:
  - Stimulus: req0 and req1 both valid at reset release, each with a 2-byte packet.
  - Expected: req0's packet is sent first, then req1's. A repeat with both valid sends req1's packet first, then req0's.
- Packet lock:
  - Stimulus: req1 asserts valid after req0's first byte.
  - Expected: req_ready[1]=0 and no req1 bytes until req0's last byte, with no interleaving.
- Backpressure:
  - Stimulus: hold tx_busy=1 for 50 cycles with req0 valid.
  - Expected: no accept and no strobe; no timeout even with HOLD_TIMEOUT=16. The byte is sent within 2 cycles of tx_busy falling.
- Timeout (HOLD_TIMEOUT=16):
  - Stimulus: req0 sends 1 non-last byte, then drops valid.
  - Expected: grant clears 16 cycles into HOLD and a pending req1 is then granted.
- Reset mid-packet:
  - Stimulus: assert rst in the SEND cycle.
  - Expected: new_tx_data, grant and tx_data go to 0 immediately (asynchronously). After release, a fresh request from req1 with req0 also valid grants req0 first (p=0).
